// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per RUN cycle, LSB slice first,
// with the carry held in a register between slices and a start/done handshake.
module chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice;
  logic             c_msb;

  // Slice adder plus next-state/output logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    a_sl    = '0;
    b_sl    = '0;

    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(c_q);
    // Carry into the slice MSB recovered from its sum bit and operand bits
    c_msb = slice[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
          k_d     = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (k_q == KW'(i)) sum_d[i*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        end
        c_d = slice[CHUNK];
        if (k_q == KW'(N-1)) begin
          cout_d  = slice[CHUNK];
          ovf_d   = c_msb ^ slice[CHUNK];
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          k_d    = k_q + KW'(1);
          busy_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
